// File: rtl/imem_boot_loader.sv
// Boot loader that streams a little-endian program image into the instruction memory.
// The core is held in reset until the image is loaded, then it gets the fetch address bus.
module imem_boot_loader #(
  parameter int DEPTH_WORDS = 4096,
  parameter int ADDR_W      = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  input  logic [31:0]       pc_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_wdata_o,
  output logic              cpu_rst_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   word_cnt_o
);

  typedef enum logic [2:0] {
    S_HDR,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH_WORDS);

  state_e          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [31:0]     n_q, n_d;
  logic [31:0]     asm_q, asm_d;
  logic [ADDR_W:0] cnt_q, cnt_d;

  logic            accept;
  logic [31:0]     n_shift;
  logic [ADDR_W:0] cnt_inc;
  logic            unused_pc;

  assign accept    = byte_valid_i && byte_ready_o;
  // Right-shifting assembly leaves the first accepted byte in bits [7:0].
  assign n_shift   = {byte_data_i, n_q[31:8]};
  assign cnt_inc   = cnt_q + (ADDR_W+1)'(1);
  assign unused_pc = ^{pc_i[31:ADDR_W+2], pc_i[1:0]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_HDR;
      idx_q   <= '0;
      n_q     <= '0;
      asm_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      asm_q   <= asm_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    asm_d   = asm_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_HDR: begin
        if (accept) begin
          n_d   = n_shift;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            if (|n_shift[31:ADDR_W+1])           state_d = S_ERR;
            else if (n_shift[ADDR_W:0] == '0)    state_d = S_DONE;
            else if (n_shift[ADDR_W:0] > DEPTH_L) state_d = S_ERR;
            else                                 state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          asm_d = {byte_data_i, asm_q[31:8]};
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        cnt_d   = cnt_inc;
        state_d = (cnt_inc == n_q[ADDR_W:0]) ? S_DONE : S_DATA;
      end
      S_DONE, S_ERR: begin
        if (start_i) begin
          state_d = S_HDR;
          cnt_d   = '0;
          n_d     = '0;
          idx_d   = '0;
        end
      end
      default: state_d = S_HDR;
    endcase
  end

  assign byte_ready_o = (state_q == S_HDR) || (state_q == S_DATA);
  assign busy_o       = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_WRITE);
  assign done_o       = (state_q == S_DONE);
  assign err_o        = (state_q == S_ERR);
  assign cpu_rst_o    = (state_q != S_DONE);
  assign mem_we_o     = (state_q == S_WRITE);
  assign mem_wdata_o  = asm_q;
  assign mem_addr_o   = (state_q == S_DONE) ? pc_i[ADDR_W+1:2] : cnt_q[ADDR_W-1:0];
  assign word_cnt_o   = cnt_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed self-checking bench for imem_boot_loader; a write monitor mirrors
// the instruction memory so loaded contents can be compared against constants.
module tb_imem_boot_loader;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        byte_ready_o;
  logic [31:0] pc_i;
  logic [11:0] mem_addr_o;
  logic        mem_we_o;
  logic [31:0] mem_wdata_o;
  logic        cpu_rst_o, busy_o, done_o, err_o;
  logic [12:0] word_cnt_o;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  logic [31:0] tb_mem [4096];

  imem_boot_loader #(.DEPTH_WORDS(4096), .ADDR_W(12)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i), .byte_ready_o(byte_ready_o),
    .pc_i(pc_i), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o),
    .cpu_rst_o(cpu_rst_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .word_cnt_o(word_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (mem_we_o) begin
      wr_cnt = wr_cnt + 1;
      tb_mem[mem_addr_o] = mem_wdata_o;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) tb_mem[i] = 32'hDEAD_BEEF;
    wr_cnt = 0;
  endtask

  // Presents one byte after `gap` idle cycles; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 0;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk_i);
      byte_valid_i = 1'b0;
    end
    @(negedge clk_i);
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    for (int t = 0; t < 50 && !ok; t++) begin
      if (byte_ready_o) begin
        @(posedge clk_i);
        ok = 1;
      end else begin
        @(negedge clk_i);
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_byte_timeout: byte %02h not accepted, ready=%0b required 1", b, byte_ready_o);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send_byte(w[7:0], gap);
    send_byte(w[15:8], gap);
    send_byte(w[23:16], gap);
    send_byte(w[31:24], gap);
  endtask

  task automatic idle();
    @(negedge clk_i);
    byte_valid_i = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (!done_o && t < 40) begin
      @(negedge clk_i);
      t++;
    end
    checks++;
    if (done_o !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_timeout: done_o=%0b required 1", name, done_o);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({byte_ready_o, busy_o, cpu_rst_o, done_o, err_o, mem_we_o} !== 6'b111000) begin
      errors++;
      $display("FAIL reset_outputs: ready/busy/cpurst/done/err/we=%06b required 111000",
               {byte_ready_o, busy_o, cpu_rst_o, done_o, err_o, mem_we_o});
    end
    checks++;
    if (word_cnt_o !== 13'd0 || mem_addr_o !== 12'd0) begin
      errors++;
      $display("FAIL reset_count: word_cnt=%0d addr=%0d required 0 0", word_cnt_o, mem_addr_o);
    end
  endtask

  task automatic test_normal_load();
    clear_mem();
    send_word(32'h0000_0002, 0);
    send_word(32'h0050_0093, 0);
    send_word(32'h0010_0113, 0);
    @(negedge clk_i);
    checks++;
    if (mem_we_o !== 1'b1 || mem_addr_o !== 12'd1 || mem_wdata_o !== 32'h0010_0113 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL normal_write1: we=%0b addr=%0d data=%08h done=%0b required 1 1 00100113 0",
               mem_we_o, mem_addr_o, mem_wdata_o, done_o);
    end
    byte_valid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (done_o !== 1'b1 || cpu_rst_o !== 1'b0 || busy_o !== 1'b0 || mem_we_o !== 1'b0 || word_cnt_o !== 13'd2) begin
      errors++;
      $display("FAIL normal_done: done=%0b cpurst=%0b busy=%0b we=%0b cnt=%0d required 1 0 0 0 2",
               done_o, cpu_rst_o, busy_o, mem_we_o, word_cnt_o);
    end
    checks++;
    if (tb_mem[0] !== 32'h0050_0093 || tb_mem[1] !== 32'h0010_0113 || wr_cnt !== 2) begin
      errors++;
      $display("FAIL normal_mem: m0=%08h m1=%08h writes=%0d required 00500093 00100113 2",
               tb_mem[0], tb_mem[1], wr_cnt);
    end
    pc_i = 32'h0000_0004;
    #1;
    checks++;
    if (mem_addr_o !== 12'd1) begin
      errors++;
      $display("FAIL fetch_pc4: addr=%0d required 1", mem_addr_o);
    end
    pc_i = 32'h0000_4008;
    #1;
    checks++;
    if (mem_addr_o !== 12'd2) begin
      errors++;
      $display("FAIL fetch_wrap: addr=%0d required 2", mem_addr_o);
    end
    pc_i = 32'h0;
  endtask

  task automatic test_backpressure();
    do_reset();
    clear_mem();
    send_word(32'h0000_0002, 3);
    send_word(32'h0050_0093, 3);
    @(negedge clk_i);
    checks++;
    if (byte_ready_o !== 1'b0 || mem_we_o !== 1'b1 || mem_addr_o !== 12'd0) begin
      errors++;
      $display("FAIL bp_write_cycle: ready=%0b we=%0b addr=%0d required 0 1 0",
               byte_ready_o, mem_we_o, mem_addr_o);
    end
    start_i = 1'b1;
    send_byte(8'h13, 3);
    start_i = 1'b0;
    send_byte(8'h01, 3);
    send_byte(8'h10, 3);
    send_byte(8'h00, 3);
    idle();
    wait_done("bp");
    checks++;
    if (tb_mem[0] !== 32'h0050_0093 || tb_mem[1] !== 32'h0010_0113 || wr_cnt !== 2 || word_cnt_o !== 13'd2) begin
      errors++;
      $display("FAIL bp_mem: m0=%08h m1=%08h writes=%0d cnt=%0d required 00500093 00100113 2 2",
               tb_mem[0], tb_mem[1], wr_cnt, word_cnt_o);
    end
  endtask

  task automatic test_empty();
    clear_mem();
    pulse_start();
    send_word(32'h0000_0000, 0);
    idle();
    checks++;
    if (done_o !== 1'b1 || cpu_rst_o !== 1'b0 || word_cnt_o !== 13'd0 || wr_cnt !== 0) begin
      errors++;
      $display("FAIL empty: done=%0b cpurst=%0b cnt=%0d writes=%0d required 1 0 0 0",
               done_o, cpu_rst_o, word_cnt_o, wr_cnt);
    end
  endtask

  task automatic test_oversize();
    logic [31:0] bad [2];
    bad[0] = 32'h0000_1001;
    bad[1] = 32'h0001_0000;
    clear_mem();
    for (int k = 0; k < 2; k++) begin
      pulse_start();
      send_word(bad[k], 0);
      idle();
      checks++;
      if (err_o !== 1'b1 || byte_ready_o !== 1'b0 || cpu_rst_o !== 1'b1 || busy_o !== 1'b0 || wr_cnt !== 0) begin
        errors++;
        $display("FAIL oversize_%0d: err=%0b ready=%0b cpurst=%0b busy=%0b writes=%0d required 1 0 1 0 0",
                 k, err_o, byte_ready_o, cpu_rst_o, busy_o, wr_cnt);
      end
    end
    pulse_start();
    send_word(32'h0000_0001, 0);
    send_word(32'hCAFE_BABE, 0);
    idle();
    wait_done("recover");
    checks++;
    if (tb_mem[0] !== 32'hCAFE_BABE || wr_cnt !== 1) begin
      errors++;
      $display("FAIL recover_mem: m0=%08h writes=%0d required cafebabe 1", tb_mem[0], wr_cnt);
    end
    pulse_start();
    send_word(32'h0000_1000, 0);
    idle();
    checks++;
    if (err_o !== 1'b0 || busy_o !== 1'b1 || byte_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL max_depth_hdr: err=%0b busy=%0b ready=%0b required 0 1 1", err_o, busy_o, byte_ready_o);
    end
  endtask

  task automatic test_reset_midload();
    do_reset();
    clear_mem();
    send_word(32'h0000_0004, 0);
    send_word(32'h1111_1111, 0);
    send_word(32'h2222_2222, 0);
    send_byte(8'h33, 0);
    send_byte(8'h33, 0);
    idle();
    #2;
    rst_i = 1'b1;
    #1;
    checks++;
    if ({byte_ready_o, busy_o, cpu_rst_o, done_o, err_o, mem_we_o} !== 6'b111000 || word_cnt_o !== 13'd0) begin
      errors++;
      $display("FAIL async_reset: flags=%06b cnt=%0d required 111000 0",
               {byte_ready_o, busy_o, cpu_rst_o, done_o, err_o, mem_we_o}, word_cnt_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    send_word(32'h0000_0001, 0);
    send_word(32'hA5A5_A5A5, 0);
    idle();
    wait_done("after_reset");
    checks++;
    if (tb_mem[0] !== 32'hA5A5_A5A5 || tb_mem[1] !== 32'h2222_2222 || tb_mem[2] !== 32'hDEAD_BEEF || wr_cnt !== 3) begin
      errors++;
      $display("FAIL reset_mem: m0=%08h m1=%08h m2=%08h writes=%0d required a5a5a5a5 22222222 deadbeef 3",
               tb_mem[0], tb_mem[1], tb_mem[2], wr_cnt);
    end
  endtask

  task automatic test_reload();
    wr_cnt = 0;
    pulse_start();
    checks++;
    if (cpu_rst_o !== 1'b1 || done_o !== 1'b0 || busy_o !== 1'b1 || word_cnt_o !== 13'd0) begin
      errors++;
      $display("FAIL reload_start: cpurst=%0b done=%0b busy=%0b cnt=%0d required 1 0 1 0",
               cpu_rst_o, done_o, busy_o, word_cnt_o);
    end
    send_word(32'h0000_0001, 0);
    send_word(32'h7777_0001, 0);
    idle();
    wait_done("reload");
    checks++;
    if (tb_mem[0] !== 32'h7777_0001 || tb_mem[1] !== 32'h2222_2222 || wr_cnt !== 1 || word_cnt_o !== 13'd1) begin
      errors++;
      $display("FAIL reload_mem: m0=%08h m1=%08h writes=%0d cnt=%0d required 77770001 22222222 1 1",
               tb_mem[0], tb_mem[1], wr_cnt, word_cnt_o);
    end
  endtask

  initial begin
    rst_i        = 1'b1;
    start_i      = 1'b0;
    byte_valid_i = 1'b0;
    byte_data_i  = 8'h00;
    pc_i         = 32'h0;
    test_reset();
    test_normal_load();
    test_backpressure();
    test_empty();
    test_oversize();
    test_reset_midload();
    test_reload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Boot-time sequencer for the single-port 4096-word instruction memory.
- Receives a program image as a byte stream and writes it word by word into the memory's write port. Holds the core in reset while loading.
- After the load, hands the memory address bus to the core's PC for fetch.
- Sits between the external byte source (UART/debug bridge), the instruction memory and the core reset.

Parameters:
- DEPTH_WORDS, 4096, instruction memory depth in 32-bit words.
- ADDR_W, 12, word-address width; must equal clog2(DEPTH_WORDS).

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  asynchronous, active-high reset.
- start_i  input  1  one-cycle pulse; restarts a load from DONE or ERR.
- byte_valid_i  input  1  byte source has valid data.
- byte_data_i  input  8  image byte.
- byte_ready_o  output  1  loader accepts a byte this cycle.
- pc_i  input  32  core program counter (byte address).
- mem_addr_o  output  ADDR_W  instruction memory word address.
- mem_we_o  output  1  instruction memory write enable; memory writes on the rising clk_i edge.
- mem_wdata_o  output  32  write data.
- cpu_rst_o  output  1  core reset; high while not DONE.
- busy_o  output  1  load in progress.
- done_o  output  1  image loaded, core running.
- err_o  output  1  image rejected.
- word_cnt_o  output  ADDR_W+1  words written so far.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Byte handshake: a byte transfers on a rising edge with byte_valid_i && byte_ready_o. byte_ready_o is high only in HDR and DATA.
- Byte order: bytes are little-endian. The first byte accepted in each group of 4 is bits [7:0].
- Image format: 4-byte header N (word count), then N words.

State machine:
- HDR: accept 4 bytes into the N register.
  - After the 4th byte: N==0 -> DONE; N>DEPTH_WORDS -> ERR; else -> DATA.
  - Only bits [ADDR_W:0] are compared after checking that the upper bits are zero; any nonzero upper bit -> ERR.
- DATA: accept 4 bytes into a 32-bit assembly register.
  - The cycle after the 4th byte is accepted -> WRITE.
- WRITE: exactly one cycle.
  - mem_we_o=1, mem_addr_o=word_cnt_o[ADDR_W-1:0], mem_wdata_o=assembled word.
  - word_cnt_o increments at the end of the cycle.
  - If incremented count == N -> DONE, else -> DATA.
  - byte_ready_o=0 in this cycle.
- DONE: cpu_rst_o=0, done_o=1, mem_we_o=0, mem_addr_o=pc_i[ADDR_W+1:2].
  - start_i -> HDR, with word_cnt_o, N and byte index cleared.
- ERR: err_o=1, cpu_rst_o=1, byte_ready_o=0.
  - start_i -> HDR, with the same clears as DONE.

Output rules:
- start_i is ignored in HDR, DATA and WRITE.
- mem_addr_o outside DONE equals word_cnt_o[ADDR_W-1:0].
- mem_wdata_o is held at the assembly register in all states.
- busy_o=1 in HDR, DATA and WRITE.
- cpu_rst_o, busy_o, done_o and err_o are registered (derived from the state register); no output depends combinationally on byte_valid_i.
- pc_i is ignored outside DONE; fetch addresses wrap modulo DEPTH_WORDS through truncation.

Reset values:
- Triggering: rst_i asserted at any time, including mid-word or mid-WRITE.
- State and byte index: state=HDR; byte index=0.
- Registers: N=0; assembly register=0; word_cnt_o=0.
- Outputs: mem_we_o=0; cpu_rst_o=1; busy_o=1; done_o=0; err_o=0; byte_ready_o=1.
- Partial word: a partially assembled word is discarded and never written.

Throughput: maximum one word per 5 cycles (4 accept cycles + 1 WRITE).

Test Plan:
- Normal load: N=2 (bytes 02 00 00 00), then words 0x00500093 and 0x00100113.
  - Writes: WRITE cycles at addr 0 and addr 1 with those values, one cycle each.
  - Completion: done_o=1 one cycle after the second write; cpu_rst_o drops.
  - Fetch: pc_i=0x4 gives mem_addr_o=1.
- Backpressure gaps: same image, byte_valid_i low for 3 cycles between every byte.
  - Required: identical memory contents; no byte dropped or duplicated.
  - WRITE cycle: byte_ready_o=0, and a valid byte presented then is accepted in the following DATA cycle.
- Empty image: N=0 -> DONE directly after the 4th header byte; mem_we_o never asserted; word_cnt_o=0.
- Oversize header: N=4097 (01 10 00 00), and separately N=0x00010000.
  - Both -> err_o=1, byte_ready_o=0, cpu_rst_o=1, no writes.
  - Then a start_i pulse followed by a valid N=1 image -> done_o=1.
- Reset mid-load: assert rst_i after 2 bytes of the 3rd word of an N=4 load.
  - Outputs return to reset values asynchronously.
  - The next image is loaded from header; word 2 of the aborted image is never written.
- Reload: in DONE, pulse start_i.
  - Response: cpu_rst_o=1, done_o=0, busy_o=1, word_cnt_o=0.
  - A new N=1 image overwrites addr 0 only.
